c64_cart_responder: RTL and testbench

//  Target side of the C64 expansion port. Responds when the 6510 owns the bus and

---
 rtl/c64_cart_responder_pkg.sv | 30 +++
 rtl/c64_cart_responder_if.sv | 41 ++++
 rtl/c64_phi2_sync.sv | 21 ++
 rtl/c64_cart_responder.sv | 172 +++++++++++++++++
 tb/tb_c64_cart_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/c64_cart_responder_pkg.sv
// rtl/c64_cart_responder_pkg.sv - shared encodings for the C64 cartridge-port responder
package c64_cart_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_READ,
        ST_WRITE,
        ST_WACK,
        ST_RELEASE
    } state_t;

    // SEL_IO1 never leaves the block; the other codes form mem_addr[14:13]
    typedef enum logic [1:0] {
        SEL_ROML = 2'b00,
        SEL_ROMH = 2'b01,
        SEL_IO2  = 2'b10,
        SEL_IO1  = 2'b11
    } sel_t;

    localparam logic [15:0] IO1_PAGE_BASE = 16'hDE00;
    localparam logic [15:0] IO2_PAGE_BASE = 16'hDF00;

    function automatic logic [14:0] mem_addr_of(sel_t sel, logic [12:0] a);
        if (sel == SEL_IO2)
            return {SEL_IO2, 5'b0, a[7:0]};
        return {sel, a};
    endfunction

endpackage

// File: rtl/c64_cart_responder_if.sv
// rtl/c64_cart_responder_if.sv - expansion-port, register-file and memory signals of the responder
interface c64_cart_responder_if #(parameter int REG_AW = 4);
    logic              c64_phi2;
    logic              c64_rw;
    logic [15:0]       c64_a_in;
    logic [7:0]        c64_d_in;
    logic              c64_roml_n;
    logic              c64_romh_n;
    logic              c64_io1_n;
    logic              c64_io2_n;
    logic              self_master;
    logic [7:0]        c64_d_out;
    logic              c64_d_oe;
    logic [REG_AW-1:0] reg_addr;
    logic              reg_wr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [14:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              late_err;

    modport slave (
        input  c64_phi2, c64_rw, c64_a_in, c64_d_in,
        input  c64_roml_n, c64_romh_n, c64_io1_n, c64_io2_n, self_master,
        input  reg_rdata, mem_rdata, mem_ack,
        output c64_d_out, c64_d_oe, reg_addr, reg_wr, reg_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata, late_err
    );

    modport master (
        output c64_phi2, c64_rw, c64_a_in, c64_d_in,
        output c64_roml_n, c64_romh_n, c64_io1_n, c64_io2_n, self_master,
        output reg_rdata, mem_rdata, mem_ack,
        input  c64_d_out, c64_d_oe, reg_addr, reg_wr, reg_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, late_err
    );
endinterface

// File: rtl/c64_phi2_sync.sv
// rtl/c64_phi2_sync.sv - PHI2 two-flop synchroniser with rise/fall detect
module c64_phi2_sync (
    input  logic clk_20,
    input  logic rst,
    input  logic phi2_async,
    output logic phi2_rise,
    output logic phi2_fall
);
    // [0] metastable, [1] synchronised, [2] previous synchronised value
    logic [2:0] sync_q;

    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[1:0], phi2_async};
    end

    assign phi2_rise = (sync_q[2:1] == 2'b01);
    assign phi2_fall = (sync_q[2:1] == 2'b10);
endmodule

// File: rtl/c64_cart_responder.sv
// rtl/c64_cart_responder.sv - C64 expansion-port target: serves CPU-phase ROML/ROMH/IO1/IO2 accesses
module c64_cart_responder
    import c64_cart_responder_pkg::*;
#(
    parameter int SETTLE_CLKS = 2,
    parameter int HOLD_CLKS   = 1,
    parameter int REG_AW      = 4
) (
    input  logic                  clk_20,
    input  logic                  rst,
    c64_cart_responder_if.slave   bus
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CLKS);
    // RELEASE is entered one cycle after the fall is seen, so that cycle counts as hold
    localparam logic [3:0] HOLD_LOAD   = 4'((HOLD_CLKS > 0) ? HOLD_CLKS - 1 : 0);

    logic        phi2_rise, phi2_fall;
    logic [4:0]  ctl_meta, ctl_sync;
    logic [12:0] a_meta, a_sync;
    logic [7:0]  d_p1, d_p2, d_p3;
    state_t      state;
    sel_t        sel, hit;
    logic [3:0]  cnt;
    logic        ack_seen;

    c64_phi2_sync u_phi2_sync (
        .clk_20     (clk_20),
        .rst        (rst),
        .phi2_async (bus.c64_phi2),
        .phi2_rise  (phi2_rise),
        .phi2_fall  (phi2_fall)
    );

    // ctl = {rw, io1_n, io2_n, roml_n, romh_n}
    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst) begin
            ctl_meta <= '1;
            ctl_sync <= '1;
            a_meta   <= '0;
            a_sync   <= '0;
            d_p1     <= '0;
            d_p2     <= '0;
            d_p3     <= '0;
        end else begin
            ctl_meta <= {bus.c64_rw, bus.c64_io1_n, bus.c64_io2_n, bus.c64_roml_n, bus.c64_romh_n};
            ctl_sync <= ctl_meta;
            a_meta   <= bus.c64_a_in[12:0];
            a_sync   <= a_meta;
            d_p1     <= bus.c64_d_in;
            d_p2     <= d_p1;
            d_p3     <= d_p2;
        end
    end

    always_comb begin
        hit = SEL_ROMH;
        if (!ctl_sync[3])      hit = SEL_IO1;
        else if (!ctl_sync[2]) hit = SEL_IO2;
        else if (!ctl_sync[1]) hit = SEL_ROML;
    end

    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sel           <= SEL_ROML;
            cnt           <= '0;
            ack_seen      <= 1'b0;
            bus.c64_d_out <= '0;
            bus.c64_d_oe  <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_wdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.late_err  <= 1'b0;
        end else begin
            bus.reg_wr   <= 1'b0;
            bus.late_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (phi2_rise) begin
                        state <= ST_SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (bus.self_master || (&ctl_sync[3:0])) begin
                        state <= ST_IDLE;
                    end else begin
                        sel          <= hit;
                        bus.reg_addr <= a_sync[REG_AW-1:0];
                        if (ctl_sync[4]) begin
                            state        <= ST_READ;
                            bus.c64_d_oe <= 1'b1;
                            ack_seen     <= (hit == SEL_IO1);
                            if (hit != SEL_IO1) begin
                                bus.mem_req  <= 1'b1;
                                bus.mem_we   <= 1'b0;
                                bus.mem_addr <= mem_addr_of(hit, a_sync);
                            end
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (sel == SEL_IO1) begin
                        bus.c64_d_out <= bus.reg_rdata;
                    end else if (bus.mem_req && bus.mem_ack) begin
                        bus.c64_d_out <= bus.mem_rdata;
                        bus.mem_req   <= 1'b0;
                        ack_seen      <= 1'b1;
                    end
                    if (phi2_fall) begin
                        state <= ST_RELEASE;
                        cnt   <= HOLD_LOAD;
                        // an ack landing on the fall cycle still counts as on time
                        if (!ack_seen && !(bus.mem_req && bus.mem_ack)) begin
                            bus.mem_req   <= 1'b0;
                            bus.late_err  <= 1'b1;
                            bus.c64_d_out <= 8'hFF;
                        end
                    end
                end
                ST_WRITE: begin
                    if (phi2_fall) begin
                        case (sel)
                            SEL_IO1: begin
                                bus.reg_wr    <= 1'b1;
                                bus.reg_wdata <= d_p3;
                                state         <= ST_IDLE;
                            end
                            SEL_IO2: begin
                                bus.mem_req   <= 1'b1;
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= mem_addr_of(SEL_IO2, a_sync);
                                bus.mem_wdata <= d_p3;
                                state         <= ST_WACK;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WACK: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (phi2_rise) begin
                        bus.mem_req  <= 1'b0;
                        bus.mem_we   <= 1'b0;
                        bus.late_err <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == 4'd0) begin
                        bus.c64_d_oe <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c64_cart_responder.sv
// tb/tb_c64_cart_responder.sv - directed scoreboard bench for c64_cart_responder
module tb_c64_cart_responder;
    import c64_cart_responder_pkg::*;

    localparam logic [1:0] K_REGWR  = 2'd0;
    localparam logic [1:0] K_MEMREQ = 2'd1;
    localparam logic [1:0] K_LATE   = 2'd2;
    localparam logic [1:0] K_RDDATA = 2'd3;

    // active-low select sets {io1_n, io2_n, roml_n, romh_n}
    localparam logic [3:0] N_NONE = 4'b1111;
    localparam logic [3:0] N_IO1  = 4'b0111;
    localparam logic [3:0] N_IO2  = 4'b1011;
    localparam logic [3:0] N_ROML = 4'b1101;
    localparam logic [3:0] N_ROMH = 4'b1110;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
    } obs_t;

    logic clk_20 = 1'b0;
    logic rst    = 1'b1;
    always #25 clk_20 = ~clk_20;

    c64_cart_responder_if #(.REG_AW(4)) bus ();

    c64_cart_responder #(.SETTLE_CLKS(2), .HOLD_CLKS(1), .REG_AW(4)) dut (
        .clk_20 (clk_20),
        .rst    (rst),
        .bus    (bus.slave)
    );

    obs_t       exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic       ack_en  = 1'b1;
    int         ack_dly = 3;
    logic       oe_any, oe_high;
    logic [7:0] dout_high;
    int         fall_oe_clks;
    logic       prev_req = 1'b0;
    logic       prev_oe  = 1'b0;
    logic [7:0] last_dout = 8'h00;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic obs_t mk(logic [1:0] k, logic we, logic [14:0] addr, logic [7:0] data);
        return '{kind: k, we: we, addr: addr, data: data};
    endfunction

    task automatic note(input obs_t o);
        obs_t e;
        check("obs_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("obs_match", 64'(o), 64'(e));
        end
    endtask

    // monitor: turns DUT events into observations and scores them against the queue
    initial begin
        forever begin
            @(negedge clk_20);
            if (rst) begin
                prev_req = 1'b0;
                prev_oe  = 1'b0;
            end else begin
                if (bus.mem_req && !prev_req)
                    note(mk(K_MEMREQ, bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00));
                if (bus.reg_wr)
                    note(mk(K_REGWR, 1'b0, {11'b0, bus.reg_addr}, bus.reg_wdata));
                if (bus.late_err)
                    note(mk(K_LATE, 1'b0, 15'h0, 8'h00));
                if (prev_oe && !bus.c64_d_oe)
                    note(mk(K_RDDATA, 1'b0, 15'h0, last_dout));
                prev_req = bus.mem_req;
                prev_oe  = bus.c64_d_oe;
                if (bus.c64_d_oe)
                    last_dout = bus.c64_d_out;
            end
        end
    end

    // memory model: acknowledges a pending request ack_dly clocks after it appears
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk_20);
            if (bus.mem_req && ack_en && !rst) begin
                repeat (ack_dly - 1) @(negedge clk_20);
                if (bus.mem_req && ack_en) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 8'hA9;
                    @(negedge clk_20);
                    bus.mem_ack   = 1'b0;
                end
            end
        end
    end

    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic [3:0] sel_n);
        @(posedge clk_20); #1;
        bus.c64_a_in = a;
        bus.c64_rw   = rw;
        bus.c64_d_in = d;
        {bus.c64_io1_n, bus.c64_io2_n, bus.c64_roml_n, bus.c64_romh_n} = sel_n;
        oe_any = 1'b0;
        oe_high = 1'b0;
        fall_oe_clks = -1;
        repeat (3) @(posedge clk_20);
        #1 bus.c64_phi2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_20);
            oe_any    = oe_any | bus.c64_d_oe;
            oe_high   = oe_high | bus.c64_d_oe;
            dout_high = bus.c64_d_out;
        end
        @(posedge clk_20); #1 bus.c64_phi2 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_20);
            @(negedge clk_20);
            oe_any = oe_any | bus.c64_d_oe;
            if (!bus.c64_d_oe && fall_oe_clks < 0)
                fall_oe_clks = i;
            if (i == 3) begin
                {bus.c64_io1_n, bus.c64_io2_n, bus.c64_roml_n, bus.c64_romh_n} = N_NONE;
                bus.c64_rw = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.c64_d_out, bus.c64_d_oe, bus.reg_addr, bus.reg_wr, bus.reg_wdata,
                    bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.late_err});
    endfunction

    initial begin
        bus.c64_phi2 = 1'b0;
        bus.c64_rw   = 1'b1;
        bus.c64_a_in = 16'h0000;
        bus.c64_d_in = 8'h00;
        {bus.c64_io1_n, bus.c64_io2_n, bus.c64_roml_n, bus.c64_romh_n} = N_NONE;
        bus.self_master = 1'b0;
        bus.reg_rdata   = 8'h00;

        repeat (3) @(posedge clk_20);
        @(negedge clk_20);
        check("reset_outputs", out_vec(), 64'd0);
        @(posedge clk_20); #1 rst = 1'b0;

        // IO1 write
        exp_q.push_back(mk(K_REGWR, 1'b0, 15'h0003, 8'h5A));
        bus_cycle(IO1_PAGE_BASE + 16'h0003, 1'b0, 8'h5A, N_IO1);
        check("io1_wr_oe_never", 64'(oe_any), 64'd0);
        check("io1_wr_drained", 64'(exp_q.size()), 64'd0);

        // IO1 read
        bus.reg_rdata = 8'hC3;
        exp_q.push_back(mk(K_RDDATA, 1'b0, 15'h0, 8'hC3));
        bus_cycle(IO1_PAGE_BASE + 16'h0007, 1'b1, 8'h00, N_IO1);
        check("io1_rd_oe_high", 64'(oe_high), 64'd1);
        check("io1_rd_dout", 64'(dout_high), 64'hC3);
        check("io1_rd_oe_release_3to4", 64'(fall_oe_clks >= 3 && fall_oe_clks <= 4), 64'd1);
        check("io1_rd_drained", 64'(exp_q.size()), 64'd0);

        // ROMH read acknowledged after 3 clocks
        ack_dly = 3;
        exp_q.push_back(mk(K_MEMREQ, 1'b0, 15'h2123, 8'h00));
        exp_q.push_back(mk(K_RDDATA, 1'b0, 15'h0, 8'hA9));
        bus_cycle(16'hE123, 1'b1, 8'h00, N_ROMH);
        check("romh_rd_dout", 64'(dout_high), 64'hA9);
        check("romh_rd_drained", 64'(exp_q.size()), 64'd0);

        // ROML read with ack withheld
        ack_en = 1'b0;
        exp_q.push_back(mk(K_MEMREQ, 1'b0, 15'h0000, 8'h00));
        exp_q.push_back(mk(K_LATE, 1'b0, 15'h0, 8'h00));
        exp_q.push_back(mk(K_RDDATA, 1'b0, 15'h0, 8'hFF));
        bus_cycle(16'h8000, 1'b1, 8'h00, N_ROML);
        check("roml_late_req_dropped", 64'(bus.mem_req), 64'd0);
        check("roml_late_drained", 64'(exp_q.size()), 64'd0);
        ack_en = 1'b1;

        // IO2 write suppressed while our BIU owns the bus, then served
        bus.self_master = 1'b1;
        bus_cycle(IO2_PAGE_BASE + 16'h0010, 1'b0, 8'h77, N_IO2);
        check("io2_selfmaster_no_req", 64'({bus.mem_req, oe_any}), 64'd0);
        bus.self_master = 1'b0;
        exp_q.push_back(mk(K_MEMREQ, 1'b1, 15'h4010, 8'h77));
        bus_cycle(IO2_PAGE_BASE + 16'h0010, 1'b0, 8'h77, N_IO2);
        check("io2_wr_done", 64'({bus.mem_req, bus.mem_we}), 64'd0);
        check("io2_wr_drained", 64'(exp_q.size()), 64'd0);

        // IO1 outranks ROML; a ROML write is ignored
        bus.reg_rdata = 8'h3C;
        exp_q.push_back(mk(K_RDDATA, 1'b0, 15'h0, 8'h3C));
        bus_cycle(16'h8005, 1'b1, 8'h00, N_IO1 & N_ROML);
        bus_cycle(16'h8006, 1'b0, 8'h12, N_ROML);
        check("prio_romlwr_drained", 64'(exp_q.size()), 64'd0);

        // IO2 write whose ack misses the next PHI2 rise
        ack_en = 1'b0;
        exp_q.push_back(mk(K_MEMREQ, 1'b1, 15'h4005, 8'h11));
        exp_q.push_back(mk(K_LATE, 1'b0, 15'h0, 8'h00));
        bus_cycle(IO2_PAGE_BASE + 16'h0005, 1'b0, 8'h11, N_IO2);
        bus_cycle(16'h0000, 1'b1, 8'h00, N_NONE);
        check("wack_late_req_dropped", 64'(bus.mem_req), 64'd0);
        check("wack_late_drained", 64'(exp_q.size()), 64'd0);
        ack_en = 1'b1;

        // reset in the middle of an IO1 read
        @(posedge clk_20); #1;
        bus.c64_a_in = IO1_PAGE_BASE;
        bus.c64_rw   = 1'b1;
        bus.c64_io1_n = 1'b0;
        repeat (3) @(posedge clk_20);
        #1 bus.c64_phi2 = 1'b1;
        for (int i = 0; i < 20 && !bus.c64_d_oe; i++)
            @(negedge clk_20);
        check("rst_pre_oe", 64'(bus.c64_d_oe), 64'd1);
        #5 rst = 1'b1;
        #1 check("rst_async_oe", 64'(bus.c64_d_oe), 64'd0);
        @(negedge clk_20);
        check("rst_hold_outputs_a", out_vec(), 64'd0);
        @(negedge clk_20);
        check("rst_hold_outputs_b", out_vec(), 64'd0);
        bus.c64_phi2 = 1'b0;
        bus.c64_io1_n = 1'b1;
        @(posedge clk_20); #1 rst = 1'b0;
        repeat (4) @(negedge clk_20);
        check("post_rst_outputs", out_vec(), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
